// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcodes, FSM state type and flag bundle shared by the alu_mc block.
// Optional feature macro: ALU_MC_MUL_EN (adds the MUL state when defined).
package alu_mc_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_SBC = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_LSR = 4'h8;
   localparam logic [3:0] OP_LSL = 4'h9;
   localparam logic [3:0] OP_ASR = 4'hA;
   localparam logic [3:0] OP_ROR = 4'hB;
   localparam logic [3:0] OP_MUL = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef ALU_MC_MUL_EN
      ST_MUL   = 2'd2,
`endif
      ST_SHIFT = 2'd1
   } state_t;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
      logic bor;
   } flags_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_LSR) || (op == OP_LSL) || (op == OP_ASR) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/alu_mc_addsub.sv
// alu_mc_addsub: combinational WIDTH-bit adder/subtractor with carry, overflow
// and borrow. Subtraction is a + ~b + ~bin, so the carry-out is ~borrow.
module alu_mc_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             c,
   output logic             v,
   output logic             bor
);

   logic [WIDTH-1:0] bx;
   logic             cx;

   // Single adder serves both directions; overflow uses the effective b operand.
   always_comb begin
      bx       = sub ? ~b : b;
      cx       = sub ? ~cin : cin;
      {c, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
      v        = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      bor      = sub & ~c;
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Arithmetic/logic ops finish in one cycle, shifts move
// one bit per cycle, MUL is a WIDTH-step shift-and-add.
// Optional feature macro: ALU_MC_MUL_EN (undefined: opcode 1100 is reserved).
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ext_cin,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             v,
   output logic             bor
);

   localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] sh_q;
   logic [SHW:0]     cnt;
   flags_t           flg;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] as_a, as_b, as_sum;
   logic             as_sub, as_cin, as_c, as_v, as_bor;
   logic [WIDTH-1:0] r_y;
   flags_t           r_f;
   logic [WIDTH-1:0] sh_nxt;
   logic             sh_out;

`ifdef ALU_MC_MUL_EN
   localparam logic [SHW:0] MUL_CYC = (SHW+1)'(WIDTH);
   logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
`endif

   assign shamt    = b[SHW-1:0];
   assign in_ready = (state == ST_IDLE) && !rst;
   assign z        = flg.z;
   assign n        = flg.n;
   assign c        = flg.c;
   assign v        = flg.v;
   assign bor      = flg.bor;

   // Shared adder operands: partial-sum add while multiplying, else the live request.
   always_comb begin
      as_a   = a;
      as_b   = b;
      as_sub = (alu_op == OP_SUB) || (alu_op == OP_SBC);
      as_cin = ((alu_op == OP_ADC) || (alu_op == OP_SBC)) ? ext_cin : 1'b0;
`ifdef ALU_MC_MUL_EN
      if (state == ST_MUL) begin
         as_a   = hi_q;
         as_b   = lo_q[0] ? mcand_q : '0;
         as_sub = 1'b0;
         as_cin = 1'b0;
      end
`endif
   end

   alu_mc_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .cin (as_cin),
      .sum (as_sum),
      .c   (as_c),
      .v   (as_v),
      .bor (as_bor)
   );

   // Single-cycle result from the request being accepted (shift by 0 passes a through).
   always_comb begin
      r_y = '0;
      r_f = '0;
      case (alu_op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            r_y     = as_sum;
            r_f.c   = as_c;
            r_f.v   = as_v;
            r_f.bor = as_bor;
         end
         OP_AND:                         r_y = a & b;
         OP_OR:                          r_y = a | b;
         OP_XOR:                         r_y = a ^ b;
         OP_NOT:                         r_y = ~a;
         OP_LSR, OP_LSL, OP_ASR, OP_ROR: r_y = a;
         default:                        r_y = '0;
      endcase
      r_f.z = (r_y == '0);
      r_f.n = r_y[WIDTH-1];
   end

   // One-bit shift step of the captured operand, plus the bit that falls out.
   always_comb begin
      sh_nxt = sh_q;
      sh_out = 1'b0;
      case (op_q)
         OP_LSR: begin sh_nxt = {1'b0, sh_q[WIDTH-1:1]};         sh_out = sh_q[0];       end
         OP_LSL: begin sh_nxt = {sh_q[WIDTH-2:0], 1'b0};         sh_out = sh_q[WIDTH-1]; end
         OP_ASR: begin sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; sh_out = sh_q[0];       end
         OP_ROR: begin sh_nxt = {sh_q[0], sh_q[WIDTH-1:1]};       sh_out = sh_q[0];       end
         default: ;
      endcase
   end

`ifdef ALU_MC_MUL_EN
   // Shift-and-add step: {carry, sum} and the multiplier register shift right together.
   always_comb begin
      hi_nxt = {as_c, as_sum[WIDTH-1:1]};
      lo_nxt = {as_sum[0], lo_q[WIDTH-1:1]};
   end
`endif

   // Control FSM and result/flag registers; results hold until the next pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         sh_q      <= '0;
         cnt       <= '0;
         y         <= '0;
         flg       <= '0;
         out_valid <= 1'b0;
`ifdef ALU_MC_MUL_EN
         hi_q      <= '0;
         lo_q      <= '0;
         mcand_q   <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q <= alu_op;
                  if (is_shift(alu_op) && (shamt != '0)) begin
                     sh_q  <= a;
                     cnt   <= {1'b0, shamt};
                     state <= ST_SHIFT;
                  end
`ifdef ALU_MC_MUL_EN
                  else if (alu_op == OP_MUL) begin
                     hi_q    <= '0;
                     lo_q    <= b;
                     mcand_q <= a;
                     cnt     <= MUL_CYC;
                     state   <= ST_MUL;
                  end
`endif
                  else begin
                     y         <= r_y;
                     flg       <= r_f;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               sh_q <= sh_nxt;
               cnt  <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  y         <= sh_nxt;
                  flg       <= '{z: (sh_nxt == '0), n: sh_nxt[WIDTH-1], c: sh_out,
                                 v: 1'b0, bor: 1'b0};
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
`ifdef ALU_MC_MUL_EN
            ST_MUL: begin
               hi_q <= hi_nxt;
               lo_q <= lo_nxt;
               cnt  <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  y         <= lo_nxt;
                  flg       <= '{z: (lo_nxt == '0), n: lo_nxt[WIDTH-1], c: (hi_nxt != '0),
                                 v: 1'b0, bor: 1'b0};
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven bench for alu_mc (WIDTH=8) with a FIFO scoreboard
// that also checks the cycle each result appears in.
// Honors ALU_MC_MUL_EN for the MUL expectations.
module tb_alu_mc;
   import alu_mc_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         ext_cin = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [3:0]   alu_op = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] y;
   logic         z, n, c, v, bor;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ext_cin(ext_cin), .alu_op(alu_op),
      .out_valid(out_valid), .y(y), .z(z), .n(n), .c(c), .v(v), .bor(bor)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic         cin;
      logic [W-1:0] y;
      logic [4:0]   f;     // {z,n,c,v,bor}
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] y;
      logic [4:0]   f;
      int           due;
      int           id;
   } exp_t;

   vec_t tv[$];
   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every out_valid pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stray_out_valid at cycle %0d: got pulse expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("y[%0d]", e.id), 32'(y), 32'(e.y));
            chk($sformatf("flags[%0d]", e.id), 32'({z, n, c, v, bor}), 32'(e.f));
            chk($sformatf("cycle[%0d]", e.id), 32'(cyc), 32'(e.due));
         end
      end
   end

   // Called at a negedge; returns at the following negedge with in_valid low.
   task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] ia, ib,
                        input logic icin, input logic [W-1:0] ey, input logic [4:0] ef,
                        input int lat);
      int k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout[%0d]: in_ready got 0 expected 1", id);
         return;
      end
      alu_op = op; a = ia; b = ib; ext_cin = icin; in_valid = 1'b1;
      q.push_back('{ey, ef, cyc + lat, id});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: outstanding got %0d expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         op      a      b      cin   y      {z,n,c,v,bor} lat
      tv.push_back('{OP_ADD, 8'h05, 8'h0A, 1'b0, 8'h0F, 5'b00000, 1});
      tv.push_back('{OP_SUB, 8'h0A, 8'h0F, 1'b0, 8'hFB, 5'b01001, 1});
      tv.push_back('{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 5'b01010, 1});
      tv.push_back('{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 5'b10100, 1});
      tv.push_back('{OP_SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 5'b01001, 1});
      tv.push_back('{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 5'b00110, 1});
      tv.push_back('{OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 5'b10100, 1});
      tv.push_back('{OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000, 1});
      tv.push_back('{OP_OR,  8'h0F, 8'hF0, 1'b0, 8'hFF, 5'b01000, 1});
      tv.push_back('{OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 5'b10000, 1});
      tv.push_back('{OP_NOT, 8'h0F, 8'h00, 1'b0, 8'hF0, 5'b01000, 1});
      tv.push_back('{OP_LSL, 8'h91, 8'h03, 1'b0, 8'h88, 5'b01000, 4});
      tv.push_back('{OP_LSR, 8'h91, 8'h01, 1'b0, 8'h48, 5'b00100, 2});
      tv.push_back('{OP_ASR, 8'h83, 8'h02, 1'b0, 8'hE0, 5'b01100, 3});
      tv.push_back('{OP_ROR, 8'h01, 8'h01, 1'b0, 8'h80, 5'b01100, 2});
      tv.push_back('{OP_ROR, 8'h96, 8'h07, 1'b0, 8'h2D, 5'b00000, 8});
      tv.push_back('{OP_LSL, 8'h55, 8'h08, 1'b0, 8'h55, 5'b00000, 1});
      tv.push_back('{4'hD,   8'h0C, 8'h0D, 1'b0, 8'h00, 5'b10000, 1});
`ifdef ALU_MC_MUL_EN
      tv.push_back('{OP_MUL, 8'h0C, 8'h0D, 1'b0, 8'h9C, 5'b01000, 9});
      tv.push_back('{OP_MUL, 8'h10, 8'h11, 1'b0, 8'h10, 5'b00100, 9});
`else
      tv.push_back('{OP_MUL, 8'h0C, 8'h0D, 1'b0, 8'h00, 5'b10000, 1});
      tv.push_back('{OP_MUL, 8'h10, 8'h11, 1'b0, 8'h00, 5'b10000, 1});
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_y", 32'(y), 32'h0);
      chk("rst_flags", 32'({z, n, c, v, bor}), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);

      // Vector table, issued as fast as in_ready allows
      for (int i = 0; i < tv.size(); i++)
         issue(i, tv[i].op, tv[i].a, tv[i].b, tv[i].cin, tv[i].y, tv[i].f, tv[i].lat);
      drain();

      // Four back-to-back single-cycle accepts
      issue(100, OP_ADD, 8'h21, 8'h12, 1'b0, 8'h33, 5'b00000, 1);
      issue(101, OP_AND, 8'hC3, 8'h81, 1'b0, 8'h81, 5'b01000, 1);
      issue(102, OP_XOR, 8'h0F, 8'h3C, 1'b0, 8'h33, 5'b00000, 1);
      issue(103, OP_NOT, 8'hFF, 8'h00, 1'b0, 8'h00, 5'b10000, 1);
      drain();

      // LSL busy window: in_ready low, requests and operand changes ignored
      issue(200, OP_LSL, 8'h91, 8'h03, 1'b0, 8'h88, 5'b01000, 4);
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("busy_in_ready_T+%0d", k), 32'(in_ready), 32'h0);
         in_valid = 1'b1; alu_op = OP_ADD; a = 8'hFF; b = 8'hFF;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("lsl_done_in_ready", 32'(in_ready), 32'h1);
      repeat (4) @(negedge clk);
      drain();

      // Reset at T+3 of a long operation aborts it silently
`ifdef ALU_MC_MUL_EN
      issue(300, OP_MUL, 8'h0C, 8'h0D, 1'b0, 8'h9C, 5'b01000, 9);
`else
      issue(300, OP_LSR, 8'hFF, 8'h07, 1'b0, 8'h01, 5'b00100, 8);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      #1 chk("abort_rst_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_y", 32'(y), 32'h0);
      chk("abort_flags", 32'({z, n, c, v, bor}), 32'h0);
      chk("abort_out_valid", 32'(out_valid), 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      repeat (12) @(negedge clk);

      // Recovery after abort
      issue(400, OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 5'b00000, 1);
      drain();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
